// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM stage: funct3 codes, FSM states,
// captured-instruction context and store lane/byte-enable formation.
package mem_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Instruction fields held while the memory access is outstanding
   typedef struct packed {
      logic            reg_write;
      logic            mem_to_reg;
      logic            is_load;
      logic [2:0]      funct3;
      logic [1:0]      offset;
      logic [4:0]      rd;
      logic [XLEN-1:0] alu_result;
   } mem_ctx_t;

   function automatic logic [BE_W-1:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
      logic [BE_W-1:0] be;
      case (f3[1:0])
         2'b00:   be = BE_W'(4'b0001) << off;
         2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [XLEN-1:0] calc_wdata(input logic [2:0] f3, input logic [XLEN-1:0] data);
      logic [XLEN-1:0] wdata;
      case (f3[1:0])
         2'b00:   wdata = {4{data[7:0]}};
         2'b01:   wdata = {2{data[15:0]}};
         default: wdata = data;
      endcase
      return wdata;
   endfunction

   // Illegal size/sign encodings, load+store together, or misaligned H/W
   function automatic logic access_fault(input logic rd_en, input logic wr_en,
                                         input logic [2:0] f3, input logic [1:0] off);
      logic bad_f3;
      logic misaligned;
      bad_f3     = (rd_en && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) ||
                   (wr_en && (f3 > F3_W));
      misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                   ((f3[1:0] == 2'b10) && (off != 2'b00));
      return (rd_en && wr_en) || ((rd_en || wr_en) && (bad_f3 || misaligned));
   endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word and sign/zero-extends it.
module load_align
   import mem_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic [Width-1:0] rdata,
   input  logic [1:0]       offset,
   input  logic [2:0]       funct3,
   output logic [Width-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    data = {{(Width-8){byte_sel[7]}}, byte_sel};
         F3_BU:   data = {{(Width-8){1'b0}}, byte_sel};
         F3_H:    data = {{(Width-16){half_sel[15]}}, half_sel};
         F3_HU:   data = {{(Width-16){1'b0}}, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: issues load/store over a req/ack data-memory handshake,
// stalls upstream while an access is outstanding, and owns the MEM/WB register.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MemRead_in,
   input  logic             MemWrite_in,
   input  logic             RegWrite_in,
   input  logic             MemtoReg_in,
   input  logic [Width-1:0] ALU_result_in,
   input  logic [Width-1:0] Store_data_in,
   input  logic [4:0]       Register_dest_in,
   input  logic [2:0]       funct3_in,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [Width-1:0] dmem_addr,
   output logic [Width-1:0] dmem_wdata,
   output logic [BE_W-1:0]  dmem_be,
   input  logic             dmem_ack,
   input  logic [Width-1:0] dmem_rdata,
   output logic             stall,
   output logic             mem_fault,
   output logic             RegWrite_out,
   output logic             MemtoReg_out,
   output logic [Width-1:0] Mem_data_out,
   output logic [Width-1:0] ALU_result_out,
   output logic [4:0]       Register_dest_out
);

   state_e           state_q;
   state_e           state_d;
   mem_ctx_t         ctx_q;
   logic             access_c;
   logic             fault_c;
   logic             start_c;
   logic             done_c;
   logic             pass_c;
   logic [Width-1:0] load_data_c;

   assign access_c = MemRead_in | MemWrite_in;
   assign fault_c  = access_fault(MemRead_in, MemWrite_in, funct3_in, ALU_result_in[1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (access_c && !fault_c) state_d = BUSY;
         BUSY:    if (dmem_ack)             state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stall, fault pulse and the one-hot strobes steering the registers below
   always_comb begin
      stall     = 1'b0;
      mem_fault = 1'b0;
      start_c   = 1'b0;
      done_c    = 1'b0;
      pass_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!access_c)    pass_c    = 1'b1;
            else if (fault_c) mem_fault = 1'b1;
            else begin
               stall   = 1'b1;
               start_c = 1'b1;
            end
         end
         BUSY: begin
            stall  = ~dmem_ack;
            done_c = dmem_ack;
         end
         default: ;
      endcase
   end

   // Request fields are frozen from launch until the acknowledging edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= '0;
         ctx_q      <= '0;
      end else if (start_c) begin
         dmem_req         <= 1'b1;
         dmem_we          <= MemWrite_in;
         dmem_addr        <= {ALU_result_in[Width-1:2], 2'b00};
         dmem_wdata       <= MemWrite_in ? calc_wdata(funct3_in, Store_data_in) : '0;
         dmem_be          <= calc_be(funct3_in, ALU_result_in[1:0]);
         ctx_q.reg_write  <= RegWrite_in;
         ctx_q.mem_to_reg <= MemtoReg_in;
         ctx_q.is_load    <= MemRead_in;
         ctx_q.funct3     <= funct3_in;
         ctx_q.offset     <= ALU_result_in[1:0];
         ctx_q.rd         <= Register_dest_in;
         ctx_q.alu_result <= ALU_result_in;
      end else if (done_c) begin
         dmem_req <= 1'b0;
      end
   end

   load_align #(.Width(Width)) u_load_align (
      .rdata  (dmem_rdata),
      .offset (ctx_q.offset),
      .funct3 (ctx_q.funct3),
      .data   (load_data_c)
   );

   // MEM/WB register: pass-through, completed access, or bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWrite_out      <= 1'b0;
         MemtoReg_out      <= 1'b0;
         Mem_data_out      <= '0;
         ALU_result_out    <= '0;
         Register_dest_out <= '0;
      end else if (pass_c) begin
         RegWrite_out      <= RegWrite_in;
         MemtoReg_out      <= MemtoReg_in;
         Mem_data_out      <= '0;
         ALU_result_out    <= ALU_result_in;
         Register_dest_out <= Register_dest_in;
      end else if (done_c) begin
         RegWrite_out      <= ctx_q.reg_write;
         MemtoReg_out      <= ctx_q.mem_to_reg;
         Mem_data_out      <= ctx_q.is_load ? load_data_c : '0;
         ALU_result_out    <= ctx_q.alu_result;
         Register_dest_out <= ctx_q.rd;
      end else begin
         RegWrite_out      <= 1'b0;
         MemtoReg_out      <= 1'b0;
         Mem_data_out      <= '0;
         ALU_result_out    <= '0;
         Register_dest_out <= '0;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: random instruction stream, a memory
// responder with random latency, and a MEM/WB monitor checked against a model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
   logic [31:0] ALU_result_in, Store_data_in;
   logic [4:0]  Register_dest_in;
   logic [2:0]  funct3_in;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        stall, mem_fault;
   logic        RegWrite_out, MemtoReg_out;
   logic [31:0] Mem_data_out, ALU_result_out;
   logic [4:0]  Register_dest_out;

   always #5 clk = ~clk;

   mem_access_stage #(.Width(32)) dut (
      .clk(clk), .rst(rst),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
      .ALU_result_in(ALU_result_in), .Store_data_in(Store_data_in),
      .Register_dest_in(Register_dest_in), .funct3_in(funct3_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .mem_fault(mem_fault),
      .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
      .Mem_data_out(Mem_data_out), .ALU_result_out(ALU_result_out),
      .Register_dest_out(Register_dest_out)
   );

   typedef struct {
      bit          mrd, mwr, rw, m2r;
      logic [31:0] addr, sdata, rdata;
      logic [4:0]  rd;
      logic [2:0]  f3;
      int          delay;
   } instr_t;

   typedef struct packed {
      logic        rw, m2r;
      logic [31:0] mdata, alu;
      logic [4:0]  rd;
   } wb_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      int          delay;
      logic [31:0] rdata;
   } rsp_t;

   wb_t    wb_q[$];
   req_t   req_q[$];
   rsp_t   rsp_q[$];
   instr_t prog[$];

   int n_vec  = 0;
   int n_fail = 0;
   bit rsp_en = 0;
   bit mon_en = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned size_of(input logic [2:0] f3);
      return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit model_fault(input instr_t in);
      bit legal_load, legal_store;
      legal_load  = (in.f3 == 3'd0 || in.f3 == 3'd1 || in.f3 == 3'd2 || in.f3 == 3'd4 || in.f3 == 3'd5);
      legal_store = (in.f3 <= 3'd2);
      if (in.mrd && in.mwr) return 1;
      if (in.mrd && !legal_load) return 1;
      if (in.mwr && !legal_store) return 1;
      if ((in.mrd || in.mwr) && (in.addr % size_of(in.f3) != 0)) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input int unsigned off);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (8 * off)) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
         3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic req_t model_req(input instr_t in);
      req_t r;
      int unsigned n, off;
      n       = size_of(in.f3);
      off     = in.addr % 4;
      r.we    = in.mwr;
      r.addr  = in.addr - off;
      r.be    = 4'(((32'd1 << n) - 32'd1) << off);
      r.wdata = (n == 1) ? (in.sdata & 32'hFF) * 32'h01010101 :
                (n == 2) ? (in.sdata & 32'hFFFF) * 32'h00010001 : in.sdata;
      return r;
   endfunction

   function automatic instr_t mk(input bit mrd, input bit mwr, input bit rw, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                                 input int delay, input logic [31:0] rdata);
      instr_t in;
      in.mrd = mrd; in.mwr = mwr; in.rw = rw; in.m2r = mrd; in.f3 = f3;
      in.addr = addr; in.sdata = sdata; in.rd = rd; in.delay = delay; in.rdata = rdata;
      return in;
   endfunction

   function automatic instr_t rnd_instr();
      instr_t in;
      int kind;
      logic [2:0] legal [5];
      int unsigned sz;
      legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      kind   = int'($urandom_range(0, 9));
      in.mrd = (kind >= 3 && kind <= 5) || kind == 9;
      in.mwr = (kind >= 6 && kind <= 8) || kind == 9;
      in.rw  = 1'($urandom);
      in.m2r = 1'($urandom);
      in.rd  = 5'($urandom);
      in.sdata = $urandom;
      in.rdata = $urandom;
      in.delay = int'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) in.f3 = 3'($urandom);
      else if (in.mwr)               in.f3 = 3'($urandom_range(0, 2));
      else                           in.f3 = legal[$urandom_range(0, 4)];
      if (!(in.mrd || in.mwr)) in.addr = $urandom | 32'h1;
      else begin
         sz = size_of(in.f3);
         in.addr = (32'($urandom_range(32'h40, 32'h3FF)) << 2);
         if ($urandom_range(0, 9) < 7) in.addr = in.addr + sz * 32'($urandom_range(0, 4 / sz - 1));
         else                          in.addr = in.addr + 32'($urandom_range(0, 3));
      end
      return in;
   endfunction

   // ---------------- driver (acts as the EX/MEM register) ----------------
   task automatic drive_idle();
      MemRead_in = 0; MemWrite_in = 0; RegWrite_in = 0; MemtoReg_in = 0;
      ALU_result_in = '0; Store_data_in = '0; Register_dest_in = '0; funct3_in = '0;
   endtask

   task automatic run_instr(input instr_t in);
      bit is_mem, flt, done;
      int cyc, exp_cyc;
      wb_t w;
      rsp_t r;
      is_mem = in.mrd || in.mwr;
      flt    = is_mem && model_fault(in);
      MemRead_in = in.mrd; MemWrite_in = in.mwr; RegWrite_in = in.rw; MemtoReg_in = in.m2r;
      ALU_result_in = in.addr; Store_data_in = in.sdata; Register_dest_in = in.rd; funct3_in = in.f3;
      if (!flt) begin
         w.rw = in.rw; w.m2r = in.m2r; w.alu = in.addr; w.rd = in.rd;
         w.mdata = in.mrd ? model_load(in.rdata, in.f3, in.addr % 4) : 32'h0;
         wb_q.push_back(w);
      end
      if (is_mem && !flt) begin
         req_q.push_back(model_req(in));
         r.delay = in.delay; r.rdata = in.rdata;
         rsp_q.push_back(r);
      end
      exp_cyc = (is_mem && !flt) ? in.delay + 2 : 1;
      cyc = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         cyc++;
         check("mem_fault", 128'(mem_fault), 128'(flt && cyc == 1));
         if (!stall) done = 1;
         else if (cyc >= 30) begin
            n_vec++; n_fail++;
            $display("FAIL stall_timeout: still stalled after %0d cycles, expected release", cyc);
            done = 1;
         end
      end
      check("occupancy_cycles", 128'(cyc), 128'(exp_cyc));
      @(posedge clk); #1;
   endtask

   // ---------------- memory responder ----------------
   initial begin
      bit   in_service;
      int   wait_cnt;
      req_t act, exp;
      rsp_t r;
      in_service = 0; wait_cnt = 0;
      dmem_ack = 0; dmem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         dmem_ack   = 0;
         dmem_rdata = $urandom;
         if (rsp_en) begin
            if (in_service && !dmem_req) begin
               n_vec++; n_fail++;
               $display("FAIL req_dropped: dmem_req=0 before ack, expected 1");
               in_service = 0;
            end
            if (dmem_req && !in_service) begin
               act = '{dmem_we, dmem_addr, dmem_be, dmem_we ? dmem_wdata : 32'h0};
               if (req_q.size() == 0 || rsp_q.size() == 0) begin
                  n_vec++; n_fail++;
                  $display("FAIL unexpected_req: addr=%0h we=%0b, expected no request", dmem_addr, dmem_we);
               end else begin
                  exp = req_q.pop_front();
                  if (!exp.we) exp.wdata = 32'h0;
                  check("dmem_request", 128'(act), 128'(exp));
                  r = rsp_q.pop_front();
                  wait_cnt = r.delay;
                  in_service = 1;
               end
            end
            if (in_service) begin
               if (wait_cnt == 0) begin
                  dmem_ack = 1; dmem_rdata = r.rdata; in_service = 0;
               end else wait_cnt--;
            end else if (!dmem_req && $urandom_range(0, 7) == 0) begin
               dmem_ack = 1;
            end
         end
      end
   end

   // ---------------- MEM/WB monitor ----------------
   always @(negedge clk) begin
      wb_t act, exp;
      if (mon_en && (RegWrite_out || MemtoReg_out || (|Mem_data_out) || (|ALU_result_out) || (|Register_dest_out))) begin
         act = '{RegWrite_out, MemtoReg_out, Mem_data_out, ALU_result_out, Register_dest_out};
         if (wb_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_wb: got %0h, expected bubble", act);
         end else begin
            exp = wb_q.pop_front();
            check("memwb", 128'(act), 128'(exp));
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 128'({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall, mem_fault}), 128'(0));
      check("reset_memwb", 128'({RegWrite_out, MemtoReg_out, Mem_data_out, ALU_result_out, Register_dest_out}), 128'(0));
      @(negedge clk); rst = 0;

      // launch a load, then reset while it is outstanding
      @(posedge clk); #1;
      MemRead_in = 1; RegWrite_in = 1; funct3_in = 3'd2; ALU_result_in = 32'h200; Register_dest_in = 5'd3;
      @(posedge clk); #1;
      check("busy_req", 128'({dmem_req, stall}), 128'({1'b1, 1'b1}));
      @(negedge clk); #2;
      drive_idle();
      rst = 1;
      #1;
      check("midbusy_reset_req", 128'({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall}), 128'(0));
      check("midbusy_reset_memwb", 128'({RegWrite_out, MemtoReg_out, Mem_data_out, ALU_result_out, Register_dest_out}), 128'(0));
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      rsp_en = 1; mon_en = 1;

      prog.push_back(mk(0, 0, 1, 3'd0, 32'h1234, 32'h0, 5'd5, 0, 32'h0));
      prog.push_back(mk(0, 1, 0, 3'd0, 32'h103, 32'hAABBCCDD, 5'd0, 3, 32'h0));
      prog.push_back(mk(1, 0, 1, 3'd0, 32'h102, 32'h0, 5'd7, 0, 32'h0080FF00));
      prog.push_back(mk(1, 0, 1, 3'd4, 32'h102, 32'h0, 5'd8, 0, 32'h0080FF00));
      prog.push_back(mk(1, 0, 1, 3'd5, 32'h102, 32'h0, 5'd9, 0, 32'h0080FF00));
      prog.push_back(mk(1, 0, 1, 3'd2, 32'h106, 32'h0, 5'd10, 0, 32'h0));
      prog.push_back(mk(1, 0, 1, 3'd2, 32'h300, 32'h0, 5'd11, 1, 32'h11223344));
      prog.push_back(mk(1, 0, 1, 3'd2, 32'h304, 32'h0, 5'd12, 1, 32'h55667788));
      repeat (250) prog.push_back(rnd_instr());

      foreach (prog[i]) run_instr(prog[i]);
      drive_idle();
      repeat (6) @(posedge clk);
      #1;
      check("wb_queue_drained", 128'(wb_q.size()), 128'(0));
      check("req_queue_drained", 128'(req_q.size() + rsp_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
